rggen_register_bus_initiator: RTL

RGGEN_REGISTER_BUS_INITIATOR -- requirements
Module: rggen_register_bus_initiator

---
 rtl/rggen_register_bus_initiator.sv | 115 +++++++++++
 1 files changed

// File: rtl/rggen_register_bus_initiator.sv
// rggen_register_bus_initiator: single-outstanding command-to-register-bus bridge with ready timeout
module rggen_register_bus_initiator #(
  parameter int ADDRESS_WIDTH  = 8,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic                     i_cmd_posted,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [1:0]               o_rsp_status,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic                     o_rsp_timeout,
  output logic                     o_register_valid,
  output logic [1:0]               o_register_access,
  output logic [ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]     o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]   o_register_strobe,
  input  logic                     i_register_ready,
  input  logic [1:0]               i_register_status,
  input  logic [BUS_WIDTH-1:0]     i_register_read_data
);
  localparam int SW = BUS_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Timeout fires in the BUS cycle whose increment would reach the limit
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;
  state_e                   state_q, state_d;
  logic [1:0]               access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
  logic [SW-1:0]            strobe_q, strobe_d;
  logic [1:0]               status_q, status_d;
  logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
  logic                     timeout_q, timeout_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     timeout_hit;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= '0;
      read_data_q  <= '0;
      timeout_q    <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      access_q     <= access_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
      timeout_q    <= timeout_d;
      count_q      <= count_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    status_d     = status_q;
    read_data_d  = read_data_q;
    timeout_d    = timeout_q;
    count_d      = count_q;
    timeout_hit  = (TIMEOUT_CYCLES > 0) && !i_register_ready && (count_q == LIMIT);
    case (state_q)
      IDLE: if (i_cmd_valid) begin
        state_d      = BUS;
        access_d     = !i_cmd_write ? 2'b10 : i_cmd_posted ? 2'b01 : 2'b11;
        address_d    = i_cmd_address;
        write_data_d = i_cmd_write ? i_cmd_write_data : '0;
        strobe_d     = i_cmd_write ? i_cmd_strobe : '1;
        count_d      = '0;
      end
      BUS: if (i_register_ready) begin
        state_d     = RSP;
        status_d    = i_register_status;
        read_data_d = (access_q == 2'b10) ? i_register_read_data : '0;
        timeout_d   = 1'b0;
      end else if (timeout_hit) begin
        state_d     = RSP;
        status_d    = 2'b11;
        read_data_d = '0;
        timeout_d   = 1'b1;
      end else begin
        count_d = (&count_q) ? count_q : count_q + 1'b1;
      end
      RSP: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign o_cmd_ready           = state_q == IDLE;
  assign o_register_valid      = state_q == BUS;
  assign o_rsp_valid           = state_q == RSP;
  assign o_register_access     = access_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;
  assign o_rsp_status          = status_q;
  assign o_rsp_read_data       = read_data_q;
  assign o_rsp_timeout         = timeout_q;
endmodule
